// File: rtl/snn_lif_layer_if.sv
// Control, weight-write and observation signals of one LIF layer.
// The producer (sequencer or testbench) uses master, the layer uses slave.
interface snn_lif_layer_if #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 2,
    parameter int W_BITS = 8,
    parameter int V_BITS = 12
);
    localparam int N_W    = N_IN * N_OUT;
    localparam int ADDR_W = (N_W > 1) ? $clog2(N_W) : 1;
    localparam int SEL_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic                     ena;
    logic                     step;
    logic [N_IN-1:0]          spike_in;
    logic [V_BITS-1:0]        threshold;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic signed [W_BITS-1:0] wr_data;
    logic [SEL_W-1:0]         v_sel;
    logic [N_OUT-1:0]         spike_out;
    logic [V_BITS-1:0]        v_out;

    modport master (
        output ena, step, spike_in, threshold, wr_en, wr_addr, wr_data, v_sel,
        input  spike_out, v_out
    );

    modport slave (
        input  ena, step, spike_in, threshold, wr_en, wr_addr, wr_data, v_sel,
        output spike_out, v_out
    );
endinterface

// File: rtl/snn_lif_layer.sv
// Fully-connected layer of leaky integrate-and-fire neurons with signed weights,
// shift leak, programmable threshold and a refractory hold-off after each spike.
module snn_lif_layer #(
    parameter int N_IN       = 3,
    parameter int N_OUT      = 2,
    parameter int W_BITS     = 8,
    parameter int V_BITS     = 12,
    parameter int LEAK_SHIFT = 2,
    parameter int REFRACTORY = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    snn_lif_layer_if.slave bus
);
    localparam int N_W    = N_IN * N_OUT;
    localparam int ADDR_W = (N_W > 1) ? $clog2(N_W) : 1;
    localparam int SEL_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int RW     = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;
    // Wide enough that V plus N_IN worst-case weights can never wrap.
    localparam int ACC_W  = V_BITS + W_BITS + $clog2(N_IN + 1) + 1;
    localparam logic [V_BITS-1:0] V_MAX = {1'b0, {(V_BITS-1){1'b1}}};

    logic signed [W_BITS-1:0] w_q    [N_W];
    logic [V_BITS-1:0]        v_q    [N_OUT];
    logic [V_BITS-1:0]        v_d    [N_OUT];
    logic [RW-1:0]            refr_q [N_OUT];
    logic [RW-1:0]            refr_d [N_OUT];
    logic [N_OUT-1:0]         spike_q;
    logic [N_OUT-1:0]         spike_d;

    logic signed [ACC_W-1:0]  acc    [N_OUT];
    logic [V_BITS-1:0]        vn     [N_OUT];
    logic [N_OUT-1:0]         fire;

    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            acc[j] = $signed(ACC_W'(v_q[j]));
            if (LEAK_SHIFT > 0) begin
                acc[j] = acc[j] - $signed(ACC_W'(v_q[j] >> LEAK_SHIFT));
            end
            for (int i = 0; i < N_IN; i++) begin
                if (bus.spike_in[i]) begin
                    acc[j] = acc[j] + ACC_W'(w_q[j*N_IN + i]);
                end
            end

            if (acc[j] < 0) begin
                vn[j] = '0;
            end else if (acc[j] > $signed(ACC_W'(V_MAX))) begin
                vn[j] = V_MAX;
            end else begin
                vn[j] = acc[j][V_BITS-1:0];
            end
            fire[j] = (vn[j] >= bus.threshold);
        end
    end

    // Outside a step cycle (or with ena low) only the spike pulse is cleared.
    always_comb begin
        spike_d = '0;
        for (int j = 0; j < N_OUT; j++) begin
            v_d[j]    = v_q[j];
            refr_d[j] = refr_q[j];
            if (bus.ena && bus.step) begin
                if (refr_q[j] != '0) begin
                    refr_d[j] = refr_q[j] - 1'b1;
                    v_d[j]    = '0;
                end else if (fire[j]) begin
                    spike_d[j] = 1'b1;
                    v_d[j]     = '0;
                    refr_d[j]  = RW'(REFRACTORY);
                end else begin
                    v_d[j] = vn[j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_W; k++) begin
                w_q[k] <= '0;
            end
            for (int j = 0; j < N_OUT; j++) begin
                v_q[j]    <= '0;
                refr_q[j] <= '0;
            end
            spike_q <= '0;
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                v_q[j]    <= v_d[j];
                refr_q[j] <= refr_d[j];
            end
            spike_q <= spike_d;
            // Addresses past the last weight match no slot and are dropped.
            if (bus.ena && bus.wr_en) begin
                for (int k = 0; k < N_W; k++) begin
                    if (bus.wr_addr == ADDR_W'(k)) begin
                        w_q[k] <= bus.wr_data;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.v_out = '0;
        for (int j = 0; j < N_OUT; j++) begin
            if (bus.v_sel == SEL_W'(j)) begin
                bus.v_out = v_q[j];
            end
        end
    end

    assign bus.spike_out = spike_q;

endmodule
